// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and widths for the IF-stage instruction fetch controller.
// Bus widths are fixed at 32 bits; the stall vector is 6 bits wide.
package if_fetch_ctrl_pkg;

  localparam int INST_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int STALL_W = 6;
  localparam int CNT_W   = 32;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_ADDR = 2'd1,
    IF_DATA = 2'd2,
    IF_DROP = 2'd3
  } if_state_e;

  // Saturating increment: sticks at all-ones instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/if_perf_cnt.sv
// Saturating 32-bit event counter with increment enable and synchronous
// active-high clear; used for the optional fetch performance counters.
module if_perf_cnt
  import if_fetch_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer over a split address/data handshake bus; buffers one word.
// Optional perf counters (fetches completed, stall cycles) under `IF_FETCH_CTRL_PERF_EN.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               ce,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  output logic               inst_req,
  output logic [ADDR_W-1:0]  inst_addr,
  input  logic               inst_addr_ok,
  input  logic               inst_data_ok,
  input  logic [INST_W-1:0]  inst_rdata,
  output logic [INST_W-1:0]  inst,
  output logic               inst_valid,
  output logic               stallreq_if
`ifdef IF_FETCH_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]   perf_fetch_cnt,
  output logic [CNT_W-1:0]   perf_wait_cnt
`endif
);

  if_state_e         state_q;
  logic              drop_q;
  logic              inst_req_q;
  logic [ADDR_W-1:0] inst_addr_q;
  logic [INST_W-1:0] inst_q;
  logic              inst_valid_q;

  // Only stall[0] (PC hold) matters to fetch; later-stage bits are ignored.
  logic unused_stall;
  assign unused_stall = ^stall[STALL_W-1:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IF_IDLE;
      drop_q       <= 1'b0;
      inst_req_q   <= 1'b0;
      inst_addr_q  <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      // Flush outranks consumption; a completing fetch below overrides both.
      if (flush)                          inst_valid_q <= 1'b0;
      else if (inst_valid_q && !stall[0]) inst_valid_q <= 1'b0;

      case (state_q)
        IF_IDLE: begin
          if (ce && !inst_valid_q && !flush) begin
            state_q     <= IF_ADDR;
            inst_req_q  <= 1'b1;
            inst_addr_q <= pc;
            drop_q      <= 1'b0;
          end
        end
        IF_ADDR: begin
          // The request must stay up until accepted; a flush only marks it doomed.
          if (inst_addr_ok) begin
            inst_req_q <= 1'b0;
            drop_q     <= 1'b0;
            state_q    <= (flush || drop_q) ? IF_DROP : IF_DATA;
          end else if (flush) begin
            drop_q <= 1'b1;
          end
        end
        IF_DATA: begin
          if (inst_data_ok) begin
            state_q <= IF_IDLE;
            if (!flush) begin
              inst_q       <= inst_rdata;
              inst_valid_q <= 1'b1;
            end
          end else if (flush) begin
            state_q <= IF_DROP;
          end
        end
        IF_DROP: begin
          if (inst_data_ok) state_q <= IF_IDLE;
        end
        default: state_q <= IF_IDLE;
      endcase
    end
  end

  assign inst_req    = inst_req_q;
  assign inst_addr   = inst_addr_q;
  assign inst        = inst_q;
  assign inst_valid  = inst_valid_q;
  assign stallreq_if = ce & ~inst_valid_q;

`ifdef IF_FETCH_CTRL_PERF_EN
  logic fetch_done;
  assign fetch_done = (state_q == IF_DATA) && inst_data_ok && !flush;

  if_perf_cnt u_fetch_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (fetch_done),
    .cnt_o (perf_fetch_cnt)
  );

  if_perf_cnt u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (stallreq_if),
    .cnt_o (perf_wait_cnt)
  );
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Testbench for if_fetch_ctrl: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_if_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        ce;
  logic [5:0]  stall;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic        stallreq_if;
`ifdef IF_FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_wait_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  if_fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .ce           (ce),
    .stall        (stall),
    .flush        (flush),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .stallreq_if  (stallreq_if)
`ifdef IF_FETCH_CTRL_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_wait_cnt  (perf_wait_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one bus transaction at a time, described by whether it
  // is live, whether its address was accepted, and whether it is doomed.
  logic        txn_live   = 1'b0;
  logic        txn_acc    = 1'b0;
  logic        txn_doomed = 1'b0;
  logic [31:0] m_addr     = '0;
  logic        m_valid    = 1'b0;
  logic [31:0] m_inst     = '0;
  logic [31:0] m_fetch    = '0;
  logic [31:0] m_wait     = '0;

  function automatic logic m_req();
    return txn_live && !txn_acc;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function void model_step();
    logic nv;
    if (rst) begin
      txn_live = 0; txn_acc = 0; txn_doomed = 0;
      m_addr = '0; m_valid = 0; m_inst = '0; m_fetch = '0; m_wait = '0;
      return;
    end
    if (ce && !m_valid) m_wait = sat_add(m_wait);
    nv = m_valid;
    if (flush) nv = 0;
    else if (m_valid && !stall[0]) nv = 0;
    if (!txn_live) begin
      if (ce && !m_valid && !flush) begin
        txn_live = 1; txn_acc = 0; txn_doomed = 0; m_addr = pc;
      end
    end else if (!txn_acc) begin
      txn_doomed = txn_doomed | flush;
      if (inst_addr_ok) txn_acc = 1;
    end else begin
      if (inst_data_ok) begin
        txn_live = 0;
        if (!txn_doomed && !flush) begin
          nv = 1; m_inst = inst_rdata; m_fetch = sat_add(m_fetch);
        end
      end else begin
        txn_doomed = txn_doomed | flush;
      end
    end
    m_valid = nv;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    ce = 0; stall = 6'b0; flush = 0; inst_addr_ok = 0; inst_data_ok = 0;
    inst_rdata = '0; pc = 32'hbfc0_0000;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  // Start a fetch of address a and leave the controller waiting for data.
  task automatic go_data(input logic [31:0] a);
    ce = 1; pc = a; inst_addr_ok = 1; inst_data_ok = 0;
    tick();
    tick();
    inst_addr_ok = 0;
  endtask

  task automatic test_reset();
    reset_dut();
    n_checks++; if (inst_req !== 1'b0) begin n_errors++; $display("FAIL rst_req: got %0h expected 0", inst_req); end
    n_checks++; if (inst_addr !== 32'h0) begin n_errors++; $display("FAIL rst_addr: got %h expected 0", inst_addr); end
    n_checks++; if (inst !== 32'h0) begin n_errors++; $display("FAIL rst_inst: got %h expected 0", inst); end
    n_checks++; if (inst_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %0h expected 0", inst_valid); end
    n_checks++; if (stallreq_if !== 1'b0) begin n_errors++; $display("FAIL rst_stallreq: got %0h expected 0", stallreq_if); end
  endtask

  task automatic test_first_fetch();
    logic [31:0] w;
    reset_dut();
    w = $urandom;
    pc = 32'hbfc0_0000; ce = 1; stall = 6'b000001; inst_addr_ok = 1; inst_data_ok = 1; inst_rdata = w;
    #1;
    n_checks++; if (stallreq_if !== 1'b1) begin n_errors++; $display("FAIL ff_stallreq_hi: got %0h expected 1", stallreq_if); end
    tick();
    n_checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc0_0000) begin n_errors++; $display("FAIL ff_req: got req=%0h addr=%h expected req=1 addr=bfc00000", inst_req, inst_addr); end
    tick();
    n_checks++; if (inst_req !== 1'b0 || inst_valid !== 1'b0) begin n_errors++; $display("FAIL ff_data_phase: got req=%0h valid=%0h expected 0 0", inst_req, inst_valid); end
    tick();
    n_checks++; if (inst_valid !== 1'b1 || inst !== w) begin n_errors++; $display("FAIL ff_valid: got valid=%0h inst=%h expected 1 %h", inst_valid, inst, w); end
    n_checks++; if (stallreq_if !== 1'b0) begin n_errors++; $display("FAIL ff_stallreq_lo: got %0h expected 0", stallreq_if); end
    inst_addr_ok = 0; inst_data_ok = 0;
  endtask

  task automatic test_addr_delay();
    logic [31:0] w;
    reset_dut();
    w = $urandom;
    pc = 32'hbfc0_0000; ce = 1; stall = 6'b000001;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc0_0000) begin n_errors++; $display("FAIL ad_hold%0d: got req=%0h addr=%h expected 1 bfc00000", i, inst_req, inst_addr); end
      pc = 32'hbfc0_0004;
      inst_addr_ok = (i == 4);
      tick();
    end
    n_checks++; if (inst_req !== 1'b0) begin n_errors++; $display("FAIL ad_drop_req: got %0h expected 0", inst_req); end
    inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = w;
    tick();
    n_checks++; if (inst_valid !== 1'b1 || inst !== w) begin n_errors++; $display("FAIL ad_valid: got valid=%0h inst=%h expected 1 %h", inst_valid, inst, w); end
    inst_data_ok = 0;
    tick();
    n_checks++; if (inst_req !== 1'b0) begin n_errors++; $display("FAIL ad_no_second: got %0h expected 0", inst_req); end
  endtask

  task automatic test_flush_data();
    reset_dut();
    go_data(32'hbfc0_0100);
    flush = 1; pc = 32'h8000_0200;
    tick();
    flush = 0;
    n_checks++; if (inst_req !== 1'b0) begin n_errors++; $display("FAIL fd_drop_req0: got %0h expected 0", inst_req); end
    tick();
    n_checks++; if (inst_req !== 1'b0) begin n_errors++; $display("FAIL fd_drop_req1: got %0h expected 0", inst_req); end
    inst_data_ok = 1; inst_rdata = 32'hDEAD_BEEF;
    tick();
    inst_data_ok = 0;
    n_checks++; if (inst_valid !== 1'b0 || inst !== 32'h0) begin n_errors++; $display("FAIL fd_discard: got valid=%0h inst=%h expected 0 0", inst_valid, inst); end
    tick();
    n_checks++; if (inst_req !== 1'b1 || inst_addr !== 32'h8000_0200) begin n_errors++; $display("FAIL fd_refetch: got req=%0h addr=%h expected 1 80000200", inst_req, inst_addr); end
  endtask

  task automatic test_flush_same_cycle();
    reset_dut();
    go_data(32'hbfc0_0010);
    flush = 1; inst_data_ok = 1; inst_rdata = 32'h1234_5678;
    tick();
    flush = 0; inst_data_ok = 0;
    n_checks++; if (inst_valid !== 1'b0 || inst_req !== 1'b0) begin n_errors++; $display("FAIL fs_data: got valid=%0h req=%0h expected 0 0", inst_valid, inst_req); end
    tick();
    n_checks++; if (inst_req !== 1'b1) begin n_errors++; $display("FAIL fs_idle_restart: got %0h expected 1", inst_req); end
    inst_addr_ok = 1; flush = 1;
    tick();
    inst_addr_ok = 0; flush = 0;
    n_checks++; if (inst_req !== 1'b0) begin n_errors++; $display("FAIL fs_addr_drop0: got %0h expected 0", inst_req); end
    tick();
    n_checks++; if (inst_req !== 1'b0 || inst_valid !== 1'b0) begin n_errors++; $display("FAIL fs_addr_drop1: got req=%0h valid=%0h expected 0 0", inst_req, inst_valid); end
    inst_data_ok = 1; inst_rdata = 32'hCAFE_F00D;
    tick();
    inst_data_ok = 0;
    n_checks++; if (inst_valid !== 1'b0) begin n_errors++; $display("FAIL fs_drop_discard: got %0h expected 0", inst_valid); end
    tick();
    n_checks++; if (inst_req !== 1'b1) begin n_errors++; $display("FAIL fs_after_drop: got %0h expected 1", inst_req); end
  endtask

  task automatic test_stall_hold();
    logic [31:0] w;
    reset_dut();
    w = $urandom;
    ce = 1; stall = 6'b000001; pc = 32'hbfc0_0040; inst_addr_ok = 1; inst_data_ok = 1; inst_rdata = w;
    tick(); tick(); tick();
    inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = ~w;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (inst_valid !== 1'b1 || inst !== w || inst_req !== 1'b0) begin n_errors++; $display("FAIL sh_hold%0d: got valid=%0h inst=%h req=%0h expected 1 %h 0", i, inst_valid, inst, inst_req, w); end
      tick();
    end
    stall = 6'b0;
    tick();
    n_checks++; if (inst_valid !== 1'b0) begin n_errors++; $display("FAIL sh_consume: got %0h expected 0", inst_valid); end
    pc = 32'hbfc0_0044;
    tick();
    n_checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc0_0044) begin n_errors++; $display("FAIL sh_next_fetch: got req=%0h addr=%h expected 1 bfc00044", inst_req, inst_addr); end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    go_data(32'hbfc0_0080);
    rst = 1;
    tick();
    rst = 0; ce = 0;
    n_checks++; if (inst_req !== 1'b0 || inst_addr !== 32'h0 || inst_valid !== 1'b0 || inst !== 32'h0) begin n_errors++; $display("FAIL rm_reset: got req=%0h addr=%h valid=%0h inst=%h expected all 0", inst_req, inst_addr, inst_valid, inst); end
`ifdef IF_FETCH_CTRL_PERF_EN
    n_checks++; if (perf_fetch_cnt !== 32'h0 || perf_wait_cnt !== 32'h0) begin n_errors++; $display("FAIL rm_perf: got fetch=%0d wait=%0d expected 0 0", perf_fetch_cnt, perf_wait_cnt); end
`endif
    inst_data_ok = 1; inst_rdata = 32'h5555_AAAA;
    tick();
    inst_data_ok = 0;
    n_checks++; if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_req !== 1'b0) begin n_errors++; $display("FAIL rm_late_data: got valid=%0h inst=%h req=%0h expected 0 0 0", inst_valid, inst, inst_req); end
  endtask

  task automatic test_random();
    int bad;
    reset_dut();
    bad = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      n_checks++;
      if (inst_req !== m_req() || inst_addr !== m_addr || inst_valid !== m_valid || inst !== m_inst) begin
        n_errors++;
        if (bad < 10) $display("FAIL rnd_regs cyc %0d: got req=%0h addr=%h valid=%0h inst=%h expected %0h %h %0h %h",
                               cyc, inst_req, inst_addr, inst_valid, inst, m_req(), m_addr, m_valid, m_inst);
        bad++;
      end
`ifdef IF_FETCH_CTRL_PERF_EN
      n_checks++;
      if (perf_fetch_cnt !== m_fetch || perf_wait_cnt !== m_wait) begin
        n_errors++;
        if (bad < 10) $display("FAIL rnd_perf cyc %0d: got fetch=%0d wait=%0d expected %0d %0d", cyc, perf_fetch_cnt, perf_wait_cnt, m_fetch, m_wait);
        bad++;
      end
`endif
      rst          = ($urandom_range(0, 199) == 0);
      ce           = ($urandom_range(0, 7) != 0);
      stall        = 6'($urandom);
      flush        = ($urandom_range(0, 11) == 0);
      inst_addr_ok = ($urandom_range(0, 2) == 0);
      inst_data_ok = ($urandom_range(0, 2) == 0);
      inst_rdata   = $urandom;
      if ($urandom_range(0, 3) == 0) pc = $urandom & 32'hFFFF_FFFC;
      #1;
      n_checks++;
      if (stallreq_if !== (ce && !m_valid)) begin
        n_errors++;
        if (bad < 10) $display("FAIL rnd_stallreq cyc %0d: got %0h expected %0h", cyc, stallreq_if, (ce && !m_valid));
        bad++;
      end
      tick();
    end
    rst = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_first_fetch();
    test_addr_delay();
    test_flush_data();
    test_flush_same_cycle();
    test_stall_hold();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
